dmac_regs: RTL and testbench
============================

// Module: dmac_regs
// PURPOSE
//  AHB-Lite slave register file: the programming front-end of the DMA controller.
//  Holds channel configuration (addresses, sizes, increments, block geometry, trigger
//  select) and drives it statically into the DMA master engine. Generates the start pulse,
//  captures completion into a sticky status bit and raises the CPU interrupt.
// PARAMETERS
//  NPIRQ   8   number of peripheral request lines (irqsrc is 3 bits; fixed at 8)
// PORTS
//  HCLK       in   1   bus clock; all state on rising edge
//  HRESETn    in   1   asynchronous active-low reset
//  HSEL       in   1   slave select
//  HADDR      in   32  address; only [4:2] decoded
//  HTRANS     in   2   transfer type; transfer valid when HTRANS[1]=1
//  HWRITE     in   1   1=write
//  HSIZE      in   3   ignored; every access is treated as a full word
//  HREADY     in   1   bus ready (address phase qualifier)
//  HWDATA     in   32  write data (data phase)
//  HREADYOUT  out  1   constant 1 (zero wait states)
//  HRESP      out  1   constant 0 (OKAY)
//  HRDATA     out  32  read data (data phase)
//  saddr,daddr out 32  source/destination start address
//  ssize,dsize out 3   HSIZE encodings for load/store
//  sinc,dinc   out 3   per-beat address increments
//  bsize,bcount out 8  block size / block count, passed unchanged
//  wfi        out  1   wait for peripheral request before each beat
//  irqsrc     out  3   selects the pirq line used when wfi=1
//  pirq       out  8   peripheral requests presented to the engine
//  start      out  1   one-cycle start pulse
//  pirq_in    in   8   raw peripheral requests
//  done       in   1   engine completion strobe (1 cycle)
//  busy       in   1   engine busy level
//  irq        out  1   CPU interrupt, level
// BEHAVIOUR
//  Map (HADDR[4:2]): 0 SADDR RW | 1 DADDR RW | 2 CFG RW: [2:0]ssize [6:4]dsize
//   [10:8]sinc [14:12]dinc [16]wfi [22:20]irqsrc | 3 BLK RW: [7:0]bsize [15:8]bcount |
//   4 CTRL: [0]START (write-1, reads 0) [1]IE RW | 5 STATUS: [0]busy RO [1]DONE W1C |
//   6 PIRQ RO: [7:0] pirq. Offset 7: reads 0, writes ignored. Unused bits read 0.
//  Address phase: HSEL&HREADY&HTRANS[1] latches {addr[4:2], write, valid}. Otherwise valid=0.
//  Data phase: write commits on HCLK edge closing the data phase; reads return
//   HRDATA combinationally from the latched index; back-to-back W then R of same reg
//   returns the new value.
//  Lock: writes to SADDR/DADDR/CFG/BLK are dropped while busy=1 or start=1.
//  start: asserted the cycle after a CTRL write with bit0=1, only if busy=0; exactly one
//   cycle; START while busy is dropped (no queueing). IE writes apply regardless of busy.
//  DONE: set when done=1; cleared by STATUS write with bit1=1; set wins on collision.
//  irq = IE & DONE, combinational from flops (glitch-free); updates 1 cycle after done.
//  Reset: all registers 0, start=0, irq=0, DONE=0, IE=0; HRDATA=0 when no read pending.
//   Reset mid-transfer aborts latched data phase; no write commits.
// CONFIGURATION
//  DMAC_PIRQ_SYNC_EN defined: pirq = 2-flop synchronised pirq_in (2-cycle latency,
//   reset 0). Undefined: pirq = pirq_in directly (requests already in HCLK domain).
//  PIRQ register always reads the value presented on pirq.
// STRUCTURE
//  Shared package dmac_pkg: register index constants (REG_SADDR..REG_PIRQ), CFG/BLK/CTRL/
//   STATUS bit-field positions and widths, HTRANS encodings. Reused by the engine bench.
//  One sub-module: dmac_sync (NPIRQ-wide 2-flop synchroniser), instanced only under
//   DMAC_PIRQ_SYNC_EN.
// TESTING
//  Write SADDR=0x2000_0000, DADDR=0x2000_0100, CFG=0x0001_1122, BLK=0x0303 -> outputs
//   match, readback equal; ssize=2 dsize=2 sinc=1 dinc=1 wfi=1 irqsrc=0.
//  CTRL=0x1 with busy=0 -> start high exactly one cycle; CTRL=0x1 with busy=1 -> no start.
//  busy=1, write SADDR=0xDEAD_BEEF -> saddr and readback unchanged.
//  IE=1, pulse done -> STATUS reads 0x2, irq=1 next cycle; STATUS write 0x2 -> irq=0;
//   done coincident with clear -> DONE stays 1.
//  Macro on: pirq_in=0x80 -> pirq=0x80 after 2 cycles, PIRQ reads 0x80; macro off: same cycle.
//  Assert HRESETn low mid write data phase -> all outputs 0, no register updated.

Source files
------------

// File: rtl/dmac_pkg.sv
// Shared definitions for the DMA controller register front-end.
// Register indices, bit-field positions/widths and AHB HTRANS encodings.
package dmac_pkg;

    localparam int unsigned NPIRQ    = 8;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned SIZE_W   = 3;
    localparam int unsigned INC_W    = 3;
    localparam int unsigned IRQSRC_W = 3;
    localparam int unsigned BLK_W    = 8;

    // Register index decoded from HADDR[4:2]
    localparam logic [IDX_W-1:0] REG_SADDR  = 3'd0;
    localparam logic [IDX_W-1:0] REG_DADDR  = 3'd1;
    localparam logic [IDX_W-1:0] REG_CFG    = 3'd2;
    localparam logic [IDX_W-1:0] REG_BLK    = 3'd3;
    localparam logic [IDX_W-1:0] REG_CTRL   = 3'd4;
    localparam logic [IDX_W-1:0] REG_STATUS = 3'd5;
    localparam logic [IDX_W-1:0] REG_PIRQ   = 3'd6;

    // AHB-Lite transfer types
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // CFG field positions
    localparam int unsigned CFG_SSIZE_LSB  = 0;
    localparam int unsigned CFG_DSIZE_LSB  = 4;
    localparam int unsigned CFG_SINC_LSB   = 8;
    localparam int unsigned CFG_DINC_LSB   = 12;
    localparam int unsigned CFG_WFI_BIT    = 16;
    localparam int unsigned CFG_IRQSRC_LSB = 20;

    // BLK / CTRL / STATUS field positions
    localparam int unsigned BLK_BSIZE_LSB  = 0;
    localparam int unsigned BLK_BCOUNT_LSB = 8;
    localparam int unsigned CTRL_START_BIT = 0;
    localparam int unsigned CTRL_IE_BIT    = 1;
    localparam int unsigned STAT_BUSY_BIT  = 0;
    localparam int unsigned STAT_DONE_BIT  = 1;

    typedef struct packed {
        logic [IRQSRC_W-1:0] irqsrc;
        logic                wfi;
        logic [INC_W-1:0]    dinc;
        logic [INC_W-1:0]    sinc;
        logic [SIZE_W-1:0]   dsize;
        logic [SIZE_W-1:0]   ssize;
    } cfg_t;

    // Extract CFG fields from a bus word
    function automatic cfg_t cfg_unpack(input logic [31:0] w);
        cfg_t c;
        c.ssize  = w[CFG_SSIZE_LSB  +: SIZE_W];
        c.dsize  = w[CFG_DSIZE_LSB  +: SIZE_W];
        c.sinc   = w[CFG_SINC_LSB   +: INC_W];
        c.dinc   = w[CFG_DINC_LSB   +: INC_W];
        c.wfi    = w[CFG_WFI_BIT];
        c.irqsrc = w[CFG_IRQSRC_LSB +: IRQSRC_W];
        return c;
    endfunction

    // Place CFG fields back into a bus word, unused bits zero
    function automatic logic [31:0] cfg_pack(input cfg_t c);
        logic [31:0] w;
        w = '0;
        w[CFG_SSIZE_LSB  +: SIZE_W]   = c.ssize;
        w[CFG_DSIZE_LSB  +: SIZE_W]   = c.dsize;
        w[CFG_SINC_LSB   +: INC_W]    = c.sinc;
        w[CFG_DINC_LSB   +: INC_W]    = c.dinc;
        w[CFG_WFI_BIT]                = c.wfi;
        w[CFG_IRQSRC_LSB +: IRQSRC_W] = c.irqsrc;
        return w;
    endfunction

endpackage

// File: rtl/dmac_sync.sv
// Two-flop synchroniser for the peripheral request lines.
module dmac_sync
    import dmac_pkg::*;
#(
    parameter int unsigned W = NPIRQ
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q, meta_d;
    logic [W-1:0] sync_q, sync_d;

    // Shift the raw input through two stages
    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    // Synchroniser flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/dmac_regs.sv
// AHB-Lite register file for the DMA controller: channel configuration, start pulse,
// sticky completion status and CPU interrupt.
// Build option: DMAC_PIRQ_SYNC_EN adds a 2-flop synchroniser on pirq_in.
module dmac_regs
    import dmac_pkg::*;
(
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic              HREADY,
    input  logic [31:0]       HWDATA,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [31:0]       HRDATA,
    output logic [31:0]       saddr,
    output logic [31:0]       daddr,
    output logic [2:0]        ssize,
    output logic [2:0]        dsize,
    output logic [2:0]        sinc,
    output logic [2:0]        dinc,
    output logic [7:0]        bsize,
    output logic [7:0]        bcount,
    output logic              wfi,
    output logic [2:0]        irqsrc,
    output logic [7:0]        pirq,
    output logic              start,
    input  logic [7:0]        pirq_in,
    input  logic              done,
    input  logic              busy,
    output logic              irq
);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic             wr_q, wr_d;
    logic             vld_q, vld_d;
    logic [31:0]      saddr_q, saddr_d;
    logic [31:0]      daddr_q, daddr_d;
    cfg_t             cfg_q, cfg_d;
    logic [BLK_W-1:0] bsize_q, bsize_d;
    logic [BLK_W-1:0] bcount_q, bcount_d;
    logic             ie_q, ie_d;
    logic             dflag_q, dflag_d;
    logic             start_q, start_d;
    logic             wr_en;
    logic             cfg_wr_ok;
    logic [31:0]      rdata_c;
    logic [NPIRQ-1:0] pirq_w;
    logic             unused_ok;

    assign unused_ok = ^{HADDR[31:5], HADDR[1:0], HTRANS[0], HSIZE};

`ifdef DMAC_PIRQ_SYNC_EN
    dmac_sync #(.W(NPIRQ)) u_sync (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .d_i   (pirq_in),
        .q_o   (pirq_w)
    );
`else
    assign pirq_w = pirq_in;
`endif

    // Address-phase capture and data-phase register updates
    always_comb begin
        idx_d     = HADDR[4:2];
        wr_d      = HWRITE;
        vld_d     = HSEL & HREADY & HTRANS[1];
        saddr_d   = saddr_q;
        daddr_d   = daddr_q;
        cfg_d     = cfg_q;
        bsize_d   = bsize_q;
        bcount_d  = bcount_q;
        ie_d      = ie_q;
        dflag_d   = dflag_q;
        start_d   = 1'b0;
        wr_en     = vld_q & wr_q;
        // Configuration is frozen while the engine runs or is being kicked off
        cfg_wr_ok = wr_en & ~busy & ~start_q;

        if (cfg_wr_ok) begin
            case (idx_q)
                REG_SADDR: saddr_d = HWDATA;
                REG_DADDR: daddr_d = HWDATA;
                REG_CFG:   cfg_d   = cfg_unpack(HWDATA);
                REG_BLK: begin
                    bsize_d  = HWDATA[BLK_BSIZE_LSB  +: BLK_W];
                    bcount_d = HWDATA[BLK_BCOUNT_LSB +: BLK_W];
                end
                default: ;
            endcase
        end

        if (wr_en && idx_q == REG_CTRL) begin
            ie_d    = HWDATA[CTRL_IE_BIT];
            start_d = HWDATA[CTRL_START_BIT] & ~busy;
        end

        if (wr_en && idx_q == REG_STATUS && HWDATA[STAT_DONE_BIT]) begin
            dflag_d = 1'b0;
        end
        // A completion in the same cycle as a clear must not be lost
        if (done) begin
            dflag_d = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            idx_q    <= '0;
            wr_q     <= 1'b0;
            vld_q    <= 1'b0;
            saddr_q  <= '0;
            daddr_q  <= '0;
            cfg_q    <= '0;
            bsize_q  <= '0;
            bcount_q <= '0;
            ie_q     <= 1'b0;
            dflag_q  <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            wr_q     <= wr_d;
            vld_q    <= vld_d;
            saddr_q  <= saddr_d;
            daddr_q  <= daddr_d;
            cfg_q    <= cfg_d;
            bsize_q  <= bsize_d;
            bcount_q <= bcount_d;
            ie_q     <= ie_d;
            dflag_q  <= dflag_d;
            start_q  <= start_d;
        end
    end

    // Read mux on the latched index
    always_comb begin
        rdata_c = '0;
        case (idx_q)
            REG_SADDR: rdata_c = saddr_q;
            REG_DADDR: rdata_c = daddr_q;
            REG_CFG:   rdata_c = cfg_pack(cfg_q);
            REG_BLK: begin
                rdata_c[BLK_BSIZE_LSB  +: BLK_W] = bsize_q;
                rdata_c[BLK_BCOUNT_LSB +: BLK_W] = bcount_q;
            end
            REG_CTRL:  rdata_c[CTRL_IE_BIT] = ie_q;
            REG_STATUS: begin
                rdata_c[STAT_BUSY_BIT] = busy;
                rdata_c[STAT_DONE_BIT] = dflag_q;
            end
            REG_PIRQ:  rdata_c = 32'(pirq_w);
            default:   rdata_c = '0;
        endcase
    end

    assign HRDATA    = (vld_q & ~wr_q) ? rdata_c : '0;
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign saddr     = saddr_q;
    assign daddr     = daddr_q;
    assign ssize     = cfg_q.ssize;
    assign dsize     = cfg_q.dsize;
    assign sinc      = cfg_q.sinc;
    assign dinc      = cfg_q.dinc;
    assign wfi       = cfg_q.wfi;
    assign irqsrc    = cfg_q.irqsrc;
    assign bsize     = bsize_q;
    assign bcount    = bcount_q;
    assign pirq      = pirq_w;
    assign start     = start_q;
    assign irq       = ie_q & dflag_q;

endmodule

// File: tb/tb_dmac_regs.sv
// Self-checking bench for dmac_regs: directed scenarios followed by random register
// traffic checked against a word-level register model.
module tb_dmac_regs;
    import dmac_pkg::*;

    localparam logic [31:0] CFG_MASK = 32'h0071_7777;
    localparam logic [31:0] BLK_MASK = 32'h0000_FFFF;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic [31:0] saddr, daddr;
    logic [2:0]  ssize, dsize, sinc, dinc;
    logic [7:0]  bsize, bcount;
    logic        wfi;
    logic [2:0]  irqsrc;
    logic [7:0]  pirq;
    logic        start;
    logic [7:0]  pirq_in;
    logic        done;
    logic        busy;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    // Register model
    logic [31:0] m_saddr, m_daddr, m_cfg, m_blk;
    logic        m_ie, m_done;

    dmac_regs dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY), .HWDATA(HWDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .saddr(saddr), .daddr(daddr), .ssize(ssize), .dsize(dsize), .sinc(sinc),
        .dinc(dinc), .bsize(bsize), .bcount(bcount), .wfi(wfi), .irqsrc(irqsrc),
        .pirq(pirq), .start(start), .pirq_in(pirq_in), .done(done), .busy(busy),
        .irq(irq)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_saddr = '0; m_daddr = '0; m_cfg = '0; m_blk = '0; m_ie = 1'b0; m_done = 1'b0;
    endtask

    // Apply a committed write to the model; returns whether start should pulse
    task automatic model_write(input logic [2:0] idx, input logic [31:0] data,
                               output logic exp_start);
        exp_start = 1'b0;
        case (idx)
            REG_SADDR:  if (!busy) m_saddr = data;
            REG_DADDR:  if (!busy) m_daddr = data;
            REG_CFG:    if (!busy) m_cfg = data & CFG_MASK;
            REG_BLK:    if (!busy) m_blk = data & BLK_MASK;
            REG_CTRL: begin
                m_ie      = data[1];
                exp_start = data[0] & ~busy;
            end
            REG_STATUS: if (data[1]) m_done = 1'b0;
            default: ;
        endcase
    endtask

    function automatic logic [31:0] exp_read(input logic [2:0] idx);
        case (idx)
            REG_SADDR:  return m_saddr;
            REG_DADDR:  return m_daddr;
            REG_CFG:    return m_cfg;
            REG_BLK:    return m_blk;
            REG_CTRL:   return {30'd0, m_ie, 1'b0};
            REG_STATUS: return {30'd0, m_done, busy};
            REG_PIRQ:   return {24'd0, pirq_in};
            default:    return 32'd0;
        endcase
    endfunction

    task automatic bus_idle();
        HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0; HADDR = '0;
    endtask

    task automatic drive_addr(input logic [2:0] idx, input logic wr);
        HSEL   = 1'b1;
        HTRANS = ($urandom_range(0, 1) == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
        HWRITE = wr;
        HSIZE  = 3'($urandom_range(0, 2));
        HADDR  = $urandom();
        HADDR[4:2] = idx;
        HADDR[1:0] = 2'b00;
    endtask

    // Address phase then data phase; returns inside the data phase
    task automatic ahb_write(input logic [2:0] idx, input logic [31:0] data);
        @(negedge HCLK);
        drive_addr(idx, 1'b1);
        @(negedge HCLK);
        bus_idle();
        HWDATA = data;
    endtask

    task automatic ahb_read(input logic [2:0] idx, output logic [31:0] data);
        @(negedge HCLK);
        drive_addr(idx, 1'b0);
        @(negedge HCLK);
        data = HRDATA;
        bus_idle();
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".saddr"},  saddr, m_saddr);
        check({tag, ".daddr"},  daddr, m_daddr);
        check({tag, ".ssize"},  32'(ssize),  32'(m_cfg[2:0]));
        check({tag, ".dsize"},  32'(dsize),  32'(m_cfg[6:4]));
        check({tag, ".sinc"},   32'(sinc),   32'(m_cfg[10:8]));
        check({tag, ".dinc"},   32'(dinc),   32'(m_cfg[14:12]));
        check({tag, ".wfi"},    32'(wfi),    32'(m_cfg[16]));
        check({tag, ".irqsrc"}, 32'(irqsrc), 32'(m_cfg[22:20]));
        check({tag, ".bsize"},  32'(bsize),  32'(m_blk[7:0]));
        check({tag, ".bcount"}, 32'(bcount), 32'(m_blk[15:8]));
        check({tag, ".irq"},    32'(irq),    32'(m_ie & m_done));
        check({tag, ".start"},  32'(start),  32'd0);
        check({tag, ".hready"}, 32'(HREADYOUT), 32'd1);
        check({tag, ".hresp"},  32'(HRESP),  32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        es;
        logic [2:0]  ridx;
        logic [31:0] rdat;

        HRESETn = 1'b0; HREADY = 1'b1; HWDATA = '0; HSIZE = 3'd2;
        pirq_in = '0; done = 1'b0; busy = 1'b0;
        bus_idle();
        model_reset();

        // Reset state
        repeat (2) @(negedge HCLK);
        check_outputs("reset");
        check("reset.hrdata", HRDATA, 32'd0);
        HRESETn = 1'b1;

        // Basic programming
        ahb_write(REG_SADDR, 32'h2000_0000); model_write(REG_SADDR, 32'h2000_0000, es);
        ahb_write(REG_DADDR, 32'h2000_0100); model_write(REG_DADDR, 32'h2000_0100, es);
        ahb_write(REG_CFG,   32'h0001_1122); model_write(REG_CFG,   32'h0001_1122, es);
        ahb_write(REG_BLK,   32'h0000_0303); model_write(REG_BLK,   32'h0000_0303, es);
        @(negedge HCLK);
        check_outputs("prog");
        check("prog.ssize",  32'(ssize),  32'd2);
        check("prog.dsize",  32'(dsize),  32'd2);
        check("prog.sinc",   32'(sinc),   32'd1);
        check("prog.dinc",   32'(dinc),   32'd1);
        check("prog.wfi",    32'(wfi),    32'd1);
        check("prog.irqsrc", 32'(irqsrc), 32'd0);
        ahb_read(REG_SADDR, rd); check("rb.saddr", rd, 32'h2000_0000);
        ahb_read(REG_DADDR, rd); check("rb.daddr", rd, 32'h2000_0100);
        ahb_read(REG_CFG,   rd); check("rb.cfg",   rd, 32'h0001_1122);
        ahb_read(REG_BLK,   rd); check("rb.blk",   rd, 32'h0000_0303);
        ahb_read(3'd7,      rd); check("rb.off7",  rd, 32'd0);

        // Start pulse: exactly one cycle when idle
        ahb_write(REG_CTRL, 32'h1); model_write(REG_CTRL, 32'h1, es);
        @(negedge HCLK); check("start.pulse", 32'(start), 32'd1);
        @(negedge HCLK); check("start.fall",  32'(start), 32'd0);
        ahb_read(REG_CTRL, rd); check("rb.ctrl_start", rd, 32'd0);

        // Start dropped while busy
        busy = 1'b1;
        ahb_write(REG_CTRL, 32'h1); model_write(REG_CTRL, 32'h1, es);
        @(negedge HCLK); check("start.busy0", 32'(start), 32'd0);
        @(negedge HCLK); check("start.busy1", 32'(start), 32'd0);

        // Config locked while busy
        ahb_write(REG_SADDR, 32'hDEAD_BEEF); model_write(REG_SADDR, 32'hDEAD_BEEF, es);
        @(negedge HCLK);
        check("lock.saddr", saddr, 32'h2000_0000);
        ahb_read(REG_SADDR, rd); check("lock.rb", rd, 32'h2000_0000);
        ahb_read(REG_STATUS, rd); check("status.busy", rd, 32'h1);
        busy = 1'b0;

        // Config write in the cycle start is high is dropped
        @(negedge HCLK);
        drive_addr(REG_CTRL, 1'b1);
        @(negedge HCLK);
        HWDATA = 32'h1;
        drive_addr(REG_SADDR, 1'b1);
        @(negedge HCLK);
        HWDATA = 32'h1234_5678;
        bus_idle();
        check("slock.start", 32'(start), 32'd1);
        @(negedge HCLK);
        m_ie = 1'b0;
        check_outputs("slock");

        // Write then read back-to-back
        @(negedge HCLK);
        drive_addr(REG_DADDR, 1'b1);
        @(negedge HCLK);
        HWDATA = 32'hA5A5_0F0F;
        drive_addr(REG_DADDR, 1'b0);
        model_write(REG_DADDR, 32'hA5A5_0F0F, es);
        @(negedge HCLK);
        check("w2r.hrdata", HRDATA, 32'hA5A5_0F0F);
        bus_idle();

        // HTRANS=BUSY is not a transfer
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = HTRANS_BUSY; HWRITE = 1'b1; HADDR = {27'd0, REG_SADDR, 2'b00};
        @(negedge HCLK);
        bus_idle(); HWDATA = 32'h5555_AAAA;
        @(negedge HCLK);
        check_outputs("htbusy");

        // Interrupt and sticky DONE
        ahb_write(REG_CTRL, 32'h2); model_write(REG_CTRL, 32'h2, es);
        @(negedge HCLK);
        done = 1'b1;
        check("irq.pre", 32'(irq), 32'd0);
        @(negedge HCLK);
        done = 1'b0; m_done = 1'b1;
        check("irq.set", 32'(irq), 32'd1);
        ahb_read(REG_STATUS, rd); check("status.done", rd, 32'h2);
        ahb_write(REG_STATUS, 32'h2); model_write(REG_STATUS, 32'h2, es);
        @(negedge HCLK);
        check("irq.clr", 32'(irq), 32'd0);
        ahb_read(REG_STATUS, rd); check("status.clr", rd, 32'h0);
        // Set wins over clear
        ahb_write(REG_STATUS, 32'h2); model_write(REG_STATUS, 32'h2, es);
        done = 1'b1;
        @(negedge HCLK);
        done = 1'b0; m_done = 1'b1;
        check("irq.coll", 32'(irq), 32'd1);
        ahb_read(REG_STATUS, rd); check("status.coll", rd, 32'h2);

        // Peripheral request path
        @(negedge HCLK);
        pirq_in = 8'h80;
`ifdef DMAC_PIRQ_SYNC_EN
        #1 check("pirq.lat0", 32'(pirq), 32'd0);
        @(negedge HCLK); check("pirq.lat1", 32'(pirq), 32'd0);
        @(negedge HCLK); check("pirq.lat2", 32'(pirq), 32'h80);
`else
        #1 check("pirq.comb", 32'(pirq), 32'h80);
`endif
        ahb_read(REG_PIRQ, rd); check("rb.pirq", rd, 32'h80);

        // Random traffic against the model
        for (int it = 0; it < 60; it++) begin
            busy = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 5))
                0, 1: begin
                    ridx = 3'($urandom_range(0, 7));
                    rdat = $urandom();
                    ahb_write(ridx, rdat);
                    model_write(ridx, rdat, es);
                    @(negedge HCLK); check("rnd.start", 32'(start), 32'(es));
                    @(negedge HCLK); check_outputs("rnd.wr");
                end
                2, 3: begin
                    ridx = 3'($urandom_range(0, 7));
                    ahb_read(ridx, rd);
                    check("rnd.rd", rd, exp_read(ridx));
                end
                4: begin
                    @(negedge HCLK); done = 1'b1;
                    @(negedge HCLK); done = 1'b0; m_done = 1'b1;
                    check("rnd.irq", 32'(irq), 32'(m_ie));
                end
                default: begin
                    @(negedge HCLK); pirq_in = 8'($urandom());
                    repeat (3) @(negedge HCLK);
                    check("rnd.pirq", 32'(pirq), 32'(pirq_in));
                    ahb_read(REG_PIRQ, rd);
                    check("rnd.pirqrb", rd, exp_read(REG_PIRQ));
                end
            endcase
        end
        busy = 1'b0;

        // Reset during a write data phase
        ahb_write(REG_SADDR, 32'h1111_2222); model_write(REG_SADDR, 32'h1111_2222, es);
        @(negedge HCLK);
        drive_addr(REG_SADDR, 1'b1);
        @(negedge HCLK);
        bus_idle(); HWDATA = 32'hCAFE_F00D;
        #2 HRESETn = 1'b0;
        model_reset();
        @(negedge HCLK);
        check_outputs("rst_mid");
        check("rst_mid.hrdata", HRDATA, 32'd0);
        HRESETn = 1'b1;
        ahb_read(REG_SADDR,  rd); check("rst_mid.rb_saddr", rd, 32'd0);
        ahb_read(REG_STATUS, rd); check("rst_mid.rb_status", rd, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
